uart_cmd_master: RTL and testbench

Host-side command initiator for the UART command protocol served by the system controller. It accepts one command request at a time and serializes it into frame bytes on a byte-wide transmit handshake toward a UART transmitter. For read and ALU commands it collects the response bytes from a UART receiver's byte strobe and presents the assembled result with a completion pulse. It is used as the bench/host endpoint and as an on-chip master for loopback configurations.

---
 rtl/uart_cmd_master.sv | 193 +++++++++++++++++++
 tb/tb_uart_cmd_master.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_master.sv
// Host-side UART command initiator: serializes one command frame onto a byte handshake and
// assembles the response bytes. Define CMD_TIMEOUT_EN to add the response timeout counter.
module uart_cmd_master #(
  parameter int unsigned TIMEOUT_W = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_type,
  input  logic [3:0]           cmd_addr,
  input  logic [7:0]           cmd_wdata,
  input  logic [7:0]           cmd_op_a,
  input  logic [7:0]           cmd_op_b,
  input  logic [3:0]           cmd_fun,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  input  logic [TIMEOUT_W-1:0] timeout_limit,
  output logic                 rsp_valid,
  output logic [15:0]          rsp_data,
  output logic                 rsp_timeout
);

  typedef enum logic [1:0] {StIdle, StSend, StWaitRsp, StDone} state_e;

  state_e      state_q, state_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic [1:0]  type_q, type_d;
  logic [3:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  op_a_q, op_a_d;
  logic [7:0]  op_b_q, op_b_d;
  logic [3:0]  fun_q, fun_d;
  logic [1:0]  idx_q, idx_d;
  logic        rx_idx_q, rx_idx_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic        rsp_timeout_q, rsp_timeout_d;

  logic        accept;
  logic [7:0]  frame_byte;
  logic [1:0]  last_idx;
  logic        rx_last;
  logic        timeout_hit;

  assign accept  = cmd_valid & cmd_ready_q;
  assign rx_last = (type_q != 2'd1);

  // Frame byte and frame length decode from the captured command.
  always_comb begin
    frame_byte = 8'h00;
    last_idx   = 2'd1;
    unique case (type_q)
      2'd0: begin
        last_idx = 2'd2;
        case (idx_q)
          2'd0:    frame_byte = 8'hAA;
          2'd1:    frame_byte = {4'h0, addr_q};
          default: frame_byte = wdata_q;
        endcase
      end
      2'd1: frame_byte = (idx_q == 2'd0) ? 8'hBB : {4'h0, addr_q};
      2'd2: begin
        last_idx = 2'd3;
        case (idx_q)
          2'd0:    frame_byte = 8'hCC;
          2'd1:    frame_byte = op_a_q;
          2'd2:    frame_byte = op_b_q;
          default: frame_byte = {4'h0, fun_q};
        endcase
      end
      default: frame_byte = (idx_q == 2'd0) ? 8'hDD : {4'h0, fun_q};
    endcase
  end

`ifdef CMD_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == StWaitRsp && !rx_valid) begin
      tmo_cnt_d = (tmo_cnt_q == '1) ? tmo_cnt_q : tmo_cnt_q + TIMEOUT_W'(1);
    end
  end

  // Compared against the next count so DONE lands exactly timeout_limit cycles after entry.
  assign timeout_hit = (state_q == StWaitRsp) && !rx_valid && (timeout_limit != '0) &&
                       (tmo_cnt_d == timeout_limit);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) tmo_cnt_q <= '0;
    else      tmo_cnt_q <= tmo_cnt_d;
  end
`else
  logic unused_timeout_limit;
  assign unused_timeout_limit = ^timeout_limit;
  assign timeout_hit          = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= StIdle;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (accept) state_d = StSend;
      StSend:    if (tx_ready && idx_q == last_idx) begin
        state_d = (type_q == 2'd0) ? StDone : StWaitRsp;
      end
      StWaitRsp: if ((rx_valid && rx_idx_q == rx_last) || timeout_hit) state_d = StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    tx_valid    = (state_q == StSend);
    tx_data     = tx_valid ? frame_byte : 8'h00;
    rsp_valid   = (state_q == StDone);
    rsp_timeout = rsp_valid & rsp_timeout_q;
    cmd_ready   = cmd_ready_q;
    rsp_data    = rsp_data_q;
  end

  always_comb begin
    cmd_ready_d   = (state_d == StIdle);
    type_d        = type_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    fun_d         = fun_q;
    idx_d         = idx_q;
    rx_idx_d      = rx_idx_q;
    rsp_data_d    = rsp_data_q;
    rsp_timeout_d = rsp_timeout_q;
    if (accept) begin
      type_d  = cmd_type;
      addr_d  = cmd_addr;
      wdata_d = cmd_wdata;
      op_a_d  = cmd_op_a;
      op_b_d  = cmd_op_b;
      fun_d   = cmd_fun;
      idx_d   = 2'd0;
    end
    if (state_q == StSend && tx_ready) idx_d = idx_q + 2'd1;
    // Leaving SEND clears the response so type 0 reports zero and stray bytes never leak in.
    if (state_q == StSend && state_d != StSend) begin
      rsp_data_d    = 16'h0000;
      rx_idx_d      = 1'b0;
      rsp_timeout_d = 1'b0;
    end
    if (state_q == StWaitRsp && rx_valid) begin
      if (rx_idx_q) rsp_data_d[15:8] = rx_data;
      else          rsp_data_d[7:0]  = rx_data;
      rx_idx_d = 1'b1;
    end
    if (timeout_hit) rsp_timeout_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cmd_ready_q   <= 1'b0;
      type_q        <= 2'd0;
      addr_q        <= 4'h0;
      wdata_q       <= 8'h00;
      op_a_q        <= 8'h00;
      op_b_q        <= 8'h00;
      fun_q         <= 4'h0;
      idx_q         <= 2'd0;
      rx_idx_q      <= 1'b0;
      rsp_data_q    <= 16'h0000;
      rsp_timeout_q <= 1'b0;
    end else begin
      cmd_ready_q   <= cmd_ready_d;
      type_q        <= type_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      fun_q         <= fun_d;
      idx_q         <= idx_d;
      rx_idx_q      <= rx_idx_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

endmodule

// File: tb/tb_uart_cmd_master.sv
// Directed self-checking bench for uart_cmd_master; inputs change and outputs are sampled on
// the falling clock edge. Covers both CMD_TIMEOUT_EN builds.
module tb_uart_cmd_master;

  logic        CLK = 1'b0;
  logic        RST;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_type;
  logic [3:0]  cmd_addr, cmd_fun;
  logic [7:0]  cmd_wdata, cmd_op_a, cmd_op_b;
  logic [7:0]  tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid;
  logic [15:0] timeout_limit;
  logic        rsp_valid, rsp_timeout;
  logic [15:0] rsp_data;

  int checks   = 0;
  int failures = 0;

  uart_cmd_master #(.TIMEOUT_W(16)) dut (
    .CLK(CLK), .RST(RST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_op_a(cmd_op_a), .cmd_op_b(cmd_op_b),
    .cmd_fun(cmd_fun), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .timeout_limit(timeout_limit),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout)
  );

  always #5 CLK = ~CLK;

  // Presents a command for one edge, then scrambles the fields; returns in the first SEND cycle.
  task automatic issue(input logic [1:0] t, input logic [3:0] a, input logic [7:0] wd,
                       input logic [7:0] oa, input logic [7:0] ob, input logic [3:0] f);
    cmd_type = t; cmd_addr = a; cmd_wdata = wd; cmd_op_a = oa; cmd_op_b = ob; cmd_fun = f;
    cmd_valid = 1'b1;
    @(negedge CLK);
    cmd_valid = 1'b0;
    cmd_type = ~t; cmd_addr = ~a; cmd_wdata = ~wd; cmd_op_a = ~oa; cmd_op_b = ~ob; cmd_fun = ~f;
  endtask

  task automatic test_reset();
    RST = 1'b0; cmd_valid = 1'b0; cmd_type = 2'd0; cmd_addr = 4'h0; cmd_wdata = 8'h00;
    cmd_op_a = 8'h00; cmd_op_b = 8'h00; cmd_fun = 4'h0; tx_ready = 1'b0; rx_data = 8'h00;
    rx_valid = 1'b0; timeout_limit = 16'd0;
    repeat (2) @(negedge CLK);
    checks++;
    if ({cmd_ready, tx_valid, tx_data, rsp_valid, rsp_data, rsp_timeout} !== 28'h0) begin
      failures++;
      $display("FAIL reset_outputs got rdy=%b txv=%b txd=%h rv=%b rd=%h rt=%b want all zero",
               cmd_ready, tx_valid, tx_data, rsp_valid, rsp_data, rsp_timeout);
    end
    RST = 1'b1;
    @(negedge CLK);
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++; $display("FAIL reset_release_ready got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_rf_write();
    logic [7:0] exp [3] = '{8'hAA, 8'h05, 8'h3C};
    tx_ready = 1'b1;
    issue(2'd0, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp[i]) begin
        failures++;
        $display("FAIL wr_byte%0d got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data, exp[i]);
      end
      @(negedge CLK);
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 16'h0000 || rsp_timeout !== 1'b0 || tx_valid !== 1'b0)
    begin
      failures++;
      $display("FAIL wr_rsp got rv=%b rd=%h rt=%b txv=%b want rv=1 rd=0000 rt=0 txv=0",
               rsp_valid, rsp_data, rsp_timeout, tx_valid);
    end
    @(negedge CLK);
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL wr_idle got rv=%b rdy=%b want rv=0 rdy=1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_rf_read();
    logic [7:0] exp [2] = '{8'hBB, 8'h02};
    tx_ready = 1'b1;
    issue(2'd1, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp[i]) begin
        failures++;
        $display("FAIL rd_byte%0d got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data, exp[i]);
      end
      @(negedge CLK);
    end
    rx_valid = 1'b1; rx_data = 8'h81;
    @(negedge CLK);
    rx_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 16'h0081 || rsp_timeout !== 1'b0) begin
      failures++;
      $display("FAIL rd_rsp got rv=%b rd=%h rt=%b want rv=1 rd=0081 rt=0",
               rsp_valid, rsp_data, rsp_timeout);
    end
    @(negedge CLK);
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || rsp_data !== 16'h0081) begin
      failures++;
      $display("FAIL rd_idle got rv=%b rdy=%b rd=%h want rv=0 rdy=1 rd=0081",
               rsp_valid, cmd_ready, rsp_data);
    end
  endtask

  task automatic test_alu_stall();
    logic [7:0] exp [4] = '{8'hCC, 8'h12, 8'h34, 8'h02};
    tx_ready = 1'b0;
    issue(2'd2, 4'h0, 8'h00, 8'h12, 8'h34, 4'h2);
    for (int i = 0; i < 4; i++) begin
      tx_ready = 1'b0;
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp[i]) begin
        failures++;
        $display("FAIL alu_stall%0d got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data, exp[i]);
      end
      @(negedge CLK);
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp[i]) begin
        failures++;
        $display("FAIL alu_hold%0d got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data, exp[i]);
      end
      tx_ready = 1'b1;
      @(negedge CLK);
    end
    checks++;
    if (tx_valid !== 1'b0 || rsp_data !== 16'h0000) begin
      failures++;
      $display("FAIL alu_wait got txv=%b rd=%h want txv=0 rd=0000", tx_valid, rsp_data);
    end
    rx_valid = 1'b1; rx_data = 8'hA8;
    @(negedge CLK);
    rx_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++; $display("FAIL alu_early_rsp got %b want 0", rsp_valid);
    end
    @(negedge CLK);
    rx_valid = 1'b1; rx_data = 8'h03;
    @(negedge CLK);
    rx_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 16'h03A8) begin
      failures++;
      $display("FAIL alu_rsp got rv=%b rd=%h want rv=1 rd=03a8", rsp_valid, rsp_data);
    end
    @(negedge CLK);
  endtask

  task automatic test_stray_rx();
    tx_ready = 1'b1;
    issue(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h0);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hDD) begin
      failures++; $display("FAIL nop_byte0 got v=%b d=%h want v=1 d=dd", tx_valid, tx_data);
    end
    rx_valid = 1'b1; rx_data = 8'hFF;
    @(negedge CLK);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h00) begin
      failures++; $display("FAIL nop_byte1 got v=%b d=%h want v=1 d=00", tx_valid, tx_data);
    end
    @(negedge CLK);
    checks++;
    if (rsp_data !== 16'h0000 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL stray_ignored got rd=%h rv=%b want rd=0000 rv=0", rsp_data, rsp_valid);
    end
    rx_data = 8'h46;
    @(negedge CLK);
    rx_data = 8'h00;
    @(negedge CLK);
    rx_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 16'h0046) begin
      failures++;
      $display("FAIL nop_rsp got rv=%b rd=%h want rv=1 rd=0046", rsp_valid, rsp_data);
    end
    @(negedge CLK);
  endtask

  task automatic test_timeout();
    int early = 0;
    timeout_limit = 16'd20;
    tx_ready = 1'b1;
    issue(2'd1, 4'h3, 8'h00, 8'h00, 8'h00, 4'h0);
    @(negedge CLK);
    @(negedge CLK);
`ifdef CMD_TIMEOUT_EN
    for (int k = 0; k < 20; k++) begin
      if (rsp_valid !== 1'b0) early++;
      @(negedge CLK);
    end
    checks++;
    if (early != 0) begin
      failures++; $display("FAIL tmo_early got %0d pulses want 0", early);
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b1 || rsp_data !== 16'h0000) begin
      failures++;
      $display("FAIL tmo_rsp got rv=%b rt=%b rd=%h want rv=1 rt=1 rd=0000",
               rsp_valid, rsp_timeout, rsp_data);
    end
    @(negedge CLK);
    checks++;
    if (cmd_ready !== 1'b1 || rsp_timeout !== 1'b0) begin
      failures++;
      $display("FAIL tmo_idle got rdy=%b rt=%b want rdy=1 rt=0", cmd_ready, rsp_timeout);
    end
`else
    for (int k = 0; k < 40; k++) begin
      if (rsp_valid !== 1'b0) early++;
      @(negedge CLK);
    end
    checks++;
    if (early != 0) begin
      failures++; $display("FAIL no_tmo_pulse got %0d pulses want 0", early);
    end
    rx_valid = 1'b1; rx_data = 8'h5A;
    @(negedge CLK);
    rx_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b0 || rsp_data !== 16'h005A) begin
      failures++;
      $display("FAIL no_tmo_rsp got rv=%b rt=%b rd=%h want rv=1 rt=0 rd=005a",
               rsp_valid, rsp_timeout, rsp_data);
    end
    @(negedge CLK);
`endif
    timeout_limit = 16'd0;
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    tx_ready = 1'b1;
    issue(2'd2, 4'h0, 8'h00, 8'h12, 8'h34, 4'h2);
    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if (tx_data !== 8'h34) begin
      failures++; $display("FAIL mid_byte2 got %h want 34", tx_data);
    end
    RST = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, tx_valid, tx_data, rsp_valid, rsp_data, rsp_timeout} !== 28'h0) begin
      failures++;
      $display("FAIL mid_reset got rdy=%b txv=%b txd=%h rv=%b rd=%h rt=%b want all zero",
               cmd_ready, tx_valid, tx_data, rsp_valid, rsp_data, rsp_timeout);
    end
    repeat (2) begin
      @(negedge CLK);
      if (rsp_valid !== 1'b0) pulses++;
    end
    RST = 1'b1;
    repeat (4) begin
      @(negedge CLK);
      if (rsp_valid !== 1'b0 || tx_valid !== 1'b0) pulses++;
    end
    checks++;
    if (pulses != 0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_abandon got activity=%0d rdy=%b want 0 and rdy=1", pulses, cmd_ready);
    end
    issue(2'd1, 4'h9, 8'h00, 8'h00, 8'h00, 4'h0);
    checks++;
    if (tx_data !== 8'hBB) begin
      failures++; $display("FAIL mid_read_b0 got %h want bb", tx_data);
    end
    @(negedge CLK);
    checks++;
    if (tx_data !== 8'h09) begin
      failures++; $display("FAIL mid_read_b1 got %h want 09", tx_data);
    end
    @(negedge CLK);
    rx_valid = 1'b1; rx_data = 8'h77;
    @(negedge CLK);
    rx_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 16'h0077) begin
      failures++;
      $display("FAIL mid_read_rsp got rv=%b rd=%h want rv=1 rd=0077", rsp_valid, rsp_data);
    end
    @(negedge CLK);
  endtask

  task automatic test_back_to_back();
    tx_ready = 1'b1;
    issue(2'd0, 4'hF, 8'h00, 8'h00, 8'h00, 4'h0);
    repeat (4) @(negedge CLK);
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++; $display("FAIL b2b_ready got %b want 1", cmd_ready);
    end
    issue(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h5);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hDD) begin
      failures++; $display("FAIL b2b_byte0 got v=%b d=%h want v=1 d=dd", tx_valid, tx_data);
    end
    @(negedge CLK);
    checks++;
    if (tx_data !== 8'h05) begin
      failures++; $display("FAIL b2b_byte1 got %h want 05", tx_data);
    end
    @(negedge CLK);
    rx_valid = 1'b1; rx_data = 8'h11;
    @(negedge CLK);
    rx_data = 8'h22;
    @(negedge CLK);
    rx_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 16'h2211) begin
      failures++;
      $display("FAIL b2b_rsp got rv=%b rd=%h want rv=1 rd=2211", rsp_valid, rsp_data);
    end
    @(negedge CLK);
  endtask

  initial begin
    test_reset();
    test_rf_write();
    test_rf_read();
    test_alu_stall();
    test_stray_rx();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
